// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg (package)
//  Description : Shared definitions for the parametrised register RAM:
//                clear-sequencer state encoding, depth and byte-lane helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

   // Clear sequencer state: CLEAR zero-fills the array, IDLE serves user traffic.
   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } clr_state_e;

   // Number of words addressed by an addr_w-bit address.
   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

   // Number of byte lanes covering a width-bit word (last lane may be partial).
   function automatic int lanes_of(input int width);
      return (width + 7) / 8;
   endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clear_seq
//  Description : Zero-fill sequencer for ram_param. Walks clr_addr through
//                0..DEPTH-1 after reset release or an accepted clear_req,
//                asserting clr_we for one word per clock.
//  Ports       : clk, reset      - clock / synchronous active-high reset
//                clear_req       - request a zero-fill (accepted in IDLE only)
//                busy            - high while in CLEAR (including during reset)
//                clr_we          - write strobe for the zero-fill
//                clr_addr        - word being zeroed this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(depth_of(ADDR_W) - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         CLEAR: begin
            // Terminal compare on the last word; the increment wraps to 0
            // harmlessly because the state leaves CLEAR on the same edge.
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == LAST_ADDR) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (clear_req) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end
         end
         default: begin
            state_d    = CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign busy     = (state_q == CLEAR);
   // No array writes while reset is held; the walk restarts from 0 on release.
   assign clr_we   = (state_q == CLEAR) && !reset;
   assign clr_addr = clr_addr_q;

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/ram_param.sv
`default_nettype none
// ============================================================================
//  Module      : ram_param
//  Description : Parametrised register RAM, 2^ADDR_W words of WIDTH bits.
//                One synchronous write port, two combinational read ports
//                (no write-through bypass), hardware zero-fill after reset or
//                on clear_req. Reads return 0 while the clear is running.
//  Ports       : clk, reset      - clock / synchronous active-high reset
//                in, address, load - write data / address (also port-A read
//                                  address) / write enable
//                addr_b          - port-B read address
//                clear_req       - request zero-fill (wins over a same-cycle write)
//                wmask           - byte-lane write mask (RAM_PARAM_LANE_MASK_EN only)
//                out, out_b      - port-A / port-B read data
//                busy            - clear in progress, user writes ignored
//  Options     : `define RAM_PARAM_LANE_MASK_EN adds the wmask port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_param
   import ram_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in,
   input  logic [ADDR_W-1:0]          address,
   input  logic                       load,
   input  logic [ADDR_W-1:0]          addr_b,
   input  logic                       clear_req,
`ifdef RAM_PARAM_LANE_MASK_EN
   input  logic [lanes_of(WIDTH)-1:0] wmask,
`endif
   output logic [WIDTH-1:0]           out,
   output logic [WIDTH-1:0]           out_b,
   output logic                       busy
);

   localparam int DEPTH = depth_of(ADDR_W);
   localparam int LANES = lanes_of(WIDTH);

   // Storage is deliberately not reset; the sequencer zero-fills it.
   logic [WIDTH-1:0]  mem_q [DEPTH];

   logic              w_busy;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic [WIDTH-1:0]  w_user_bits;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [WIDTH-1:0]  w_wdata;
   logic [WIDTH-1:0]  w_wbits;

   ram_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk       (clk),
      .reset     (reset),
      .clear_req (clear_req),
      .busy      (w_busy),
      .clr_we    (w_clr_we),
      .clr_addr  (w_clr_addr)
   );

`ifdef RAM_PARAM_LANE_MASK_EN
   // Bit-level write enables from the byte-lane mask; bits beyond the last
   // full lane follow the top mask bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int LANE = ((i / 8) < (LANES - 1)) ? (i / 8) : (LANES - 1);
      assign w_user_bits[i] = wmask[LANE];
   end
`else
   assign w_user_bits = '1;
`endif

   // Sequencer zero-fill takes the port while clearing; a user write is only
   // accepted in IDLE and is dropped when clear_req arrives in the same cycle.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = address;
      w_wdata = in;
      w_wbits = w_user_bits;
      if (w_clr_we) begin
         w_we    = 1'b1;
         w_waddr = w_clr_addr;
         w_wdata = '0;
         w_wbits = '1;
      end else if (!w_busy && !reset && !clear_req && load) begin
         w_we    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         mem_q[w_waddr] <= (mem_q[w_waddr] & ~w_wbits) | (w_wdata & w_wbits);
      end
   end

   assign out   = w_busy ? '0 : mem_q[address];
   assign out_b = w_busy ? '0 : mem_q[addr_b];
   assign busy  = w_busy;

endmodule : ram_param
`default_nettype wire
